// File: rtl/led_pkg.sv
// led_pkg: shared types and defaults for the LED frame serializer.
//   led_state_e  - serializer FSM state
//   LED_WORD_W   - default bits per LED colour word
//   LED_COUNT    - default LEDs (words) per frame
package led_pkg;

    localparam int LED_WORD_W = 24;
    localparam int LED_COUNT  = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } led_state_e;

endpackage

// File: rtl/led_frame_serializer_buf.sv
// led_word_buffer: one-entry valid/ready holding register used as the
// prefetch slot of the LED frame serializer.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   clr                   - drop any held word
//   wr_valid_i/wr_data_i  - push side; a push happens when wr_ready_o is high
//   wr_ready_o            - slot is empty
//   rd_valid_o/rd_data_o  - held word
//   rd_ready_i            - pop the held word
module led_word_buffer
    import led_pkg::*;
#(
    parameter int W = LED_WORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr_valid_i,
    input  logic [W-1:0] wr_data_i,
    output logic         wr_ready_o,
    output logic         rd_valid_o,
    output logic [W-1:0] rd_data_o,
    input  logic         rd_ready_i
);

    logic         full_q;
    logic [W-1:0] data_q;

    assign wr_ready_o = !full_q;
    assign rd_valid_o = full_q;
    assign rd_data_o  = data_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (wr_valid_i && !full_q) begin
            full_q <= 1'b1;
            data_q <= wr_data_i;
        end else if (rd_ready_i && full_q) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/led_frame_serializer.sv
// led_frame_serializer: accepts N_LEDS colour words per frame over a
// valid/ready stream and shifts each out MSB-first, one bit per bit_req.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - begin a frame (ignored while busy)
//   in_valid/in_data    - word stream in; in_ready accepts it
//   bit_req             - downstream asks for the next bit
//   bit_out/bit_valid   - serial bit, bit_valid pulses when bit_out is new
//   busy                - frame in progress
//   done                - pulses with the final bit of the frame
//   underrun            - sticky, bit_req arrived with no word loaded
// Build option: LED_SERIALIZER_PREFETCH_EN adds a one-word prefetch slot
// (led_word_buffer) so consecutive words are shifted without a gap.
module led_frame_serializer
    import led_pkg::*;
#(
    parameter int W      = LED_WORD_W,
    parameter int N_LEDS = LED_COUNT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         bit_req,
    output logic         bit_out,
    output logic         bit_valid,
    output logic         busy,
    output logic         done,
    output logic         underrun
);

    localparam int BCW = $clog2(W + 1);
    localparam int WCW = $clog2(N_LEDS + 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(W - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(N_LEDS);

    led_state_e     state_q, state_d;
    logic [W-1:0]   shreg_q, shreg_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic           bit_out_q, bit_out_d;
    logic           bit_valid_q, bit_valid_d;
    logic           done_q, done_d;
    logic           underrun_q, underrun_d;
    logic           accept;
    logic           last_bit;

`ifdef LED_SERIALIZER_PREFETCH_EN
    logic         buf_wr_ready;
    logic         buf_valid;
    logic [W-1:0] buf_data;
    logic         buf_pop;
    logic         buf_push;

    assign in_ready = (state_q != ST_IDLE) && buf_wr_ready && (word_cnt_q != WORD_LAST);
    // A word arriving exactly as the current word finishes goes straight into
    // the shift register; only words arriving mid-word are parked.
    assign buf_push = accept && (state_q == ST_SHIFT) && !(bit_req && last_bit);

    led_word_buffer #(.W(W)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .clr        (start && (state_q == ST_IDLE)),
        .wr_valid_i (buf_push),
        .wr_data_i  (in_data),
        .wr_ready_o (buf_wr_ready),
        .rd_valid_o (buf_valid),
        .rd_data_o  (buf_data),
        .rd_ready_i (buf_pop)
    );
`else
    assign in_ready = (state_q == ST_LOAD);
`endif

    assign accept   = in_valid && in_ready;
    assign last_bit = (bit_cnt_q == BIT_LAST);

    assign busy      = (state_q != ST_IDLE);
    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign done      = done_q;
    assign underrun  = underrun_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        done_d      = 1'b0;
        underrun_d  = underrun_q;
`ifdef LED_SERIALIZER_PREFETCH_EN
        buf_pop     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    underrun_d = 1'b0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // The word is not shiftable until the cycle after its
                // handshake, so any request here is lost.
                if (bit_req) begin
                    underrun_d = 1'b1;
                end
                if (accept) begin
                    shreg_d    = in_data;
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (accept) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
                if (bit_req) begin
                    bit_out_d   = shreg_q[W-1];
                    bit_valid_d = 1'b1;
                    shreg_d     = {shreg_q[W-2:0], 1'b0};
                    bit_cnt_d   = bit_cnt_q + 1'b1;
                    if (last_bit) begin
                        bit_cnt_d = '0;
`ifdef LED_SERIALIZER_PREFETCH_EN
                        if (buf_valid) begin
                            shreg_d = buf_data;
                            buf_pop = 1'b1;
                        end else if (accept) begin
                            shreg_d = in_data;
                        end else if (word_cnt_q == WORD_LAST) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_LOAD;
                        end
`else
                        if (word_cnt_q == WORD_LAST) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_LOAD;
                        end
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_led_frame_serializer.sv
// Bench for led_frame_serializer: a one-word-frame instance (dut1) driven
// from a vector table, and a four-word-frame instance (dut4) for framing,
// underrun, back-to-back and reset/start corner cases. sel picks which
// instance receives stimulus and is observed.
module tb_led_frame_serializer;

    localparam int W = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, in_valid, bit_req, sel;
    logic [W-1:0] in_data;

    logic a_in_ready, a_bit_out, a_bit_valid, a_busy, a_done, a_underrun;
    logic b_in_ready, b_bit_out, b_bit_valid, b_busy, b_done, b_underrun;
    logic o_in_ready, o_bit_out, o_bit_valid, o_busy, o_done, o_underrun;

    led_frame_serializer #(.W(W), .N_LEDS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start && !sel),
        .in_valid(in_valid && !sel), .in_data(in_data), .in_ready(a_in_ready),
        .bit_req(bit_req && !sel), .bit_out(a_bit_out), .bit_valid(a_bit_valid),
        .busy(a_busy), .done(a_done), .underrun(a_underrun)
    );

    led_frame_serializer #(.W(W), .N_LEDS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start && sel),
        .in_valid(in_valid && sel), .in_data(in_data), .in_ready(b_in_ready),
        .bit_req(bit_req && sel), .bit_out(b_bit_out), .bit_valid(b_bit_valid),
        .busy(b_busy), .done(b_done), .underrun(b_underrun)
    );

    assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign o_bit_out   = sel ? b_bit_out   : a_bit_out;
    assign o_bit_valid = sel ? b_bit_valid : a_bit_valid;
    assign o_busy      = sel ? b_busy      : a_busy;
    assign o_done      = sel ? b_done      : a_done;
    assign o_underrun  = sel ? b_underrun  : a_underrun;

    int n_checks = 0;
    int n_fail   = 0;

    // pulse counters on the observed instance, sampled mid-cycle
    int nbv = 0, ndone = 0, bv_run = 0, bv_best = 0;
    always @(negedge clk) begin
        if (o_bit_valid) begin
            nbv++;
            bv_run++;
            if (bv_run > bv_best) bv_best = bv_run;
        end else begin
            bv_run = 0;
        end
        if (o_done) ndone++;
    end

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] exp_bits;
        int           gap;
    } vec_t;

    vec_t         vecs[4];
    logic [W-1:0] fw[4];
    int           abuse_w = -1, abuse_b = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("start_busy", o_busy, 1);
        check("start_in_ready", o_in_ready, 1);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        int k = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!o_in_ready && k < 20) begin
            tick;
            k++;
        end
        check("in_ready_wait", o_in_ready, 1);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic req_bit(input int gap, input logic exp_bit, input logic exp_done);
        for (int g = 1; g < gap; g++) begin
            tick;
            check("bit_valid_idle", o_bit_valid, 0);
        end
        bit_req = 1'b1;
        tick;
        bit_req = 1'b0;
        check("bit_valid", o_bit_valid, 1);
        check("bit_out", o_bit_out, exp_bit);
        check("done", o_done, exp_done);
        check("busy", o_busy, !exp_done);
    endtask

    // Sends fw[0..3] and pulls all 96 bits, one request per cycle.
    task automatic run_frame;
        for (int wi = 0; wi < 4; wi++) begin
            send_word(fw[wi]);
`ifndef LED_SERIALIZER_PREFETCH_EN
            check("in_ready_shift", o_in_ready, 0);
`endif
            if (wi == 3) check("in_ready_after_last", o_in_ready, 0);
            for (int i = 0; i < W; i++) begin
                if (wi == abuse_w && i == abuse_b) start = 1'b1;
                req_bit(1, fw[wi][W-1-i], (wi == 3) && (i == W - 1));
                start = 1'b0;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, o_in_ready, 0);
        check({tag, "_bit_out"}, o_bit_out, 0);
        check({tag, "_bit_valid"}, o_bit_valid, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_underrun"}, o_underrun, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_bv, base_done, widx;
        logic hs;

        vecs[0] = '{24'hA5F00F, 24'b1010_0101_1111_0000_0000_1111, 3};
        vecs[1] = '{24'h5A0FF0, 24'b0101_1010_0000_1111_1111_0000, 1};
        vecs[2] = '{24'h800001, 24'b1000_0000_0000_0000_0000_0001, 2};
        vecs[3] = '{24'h123456, 24'b0001_0010_0011_0100_0101_0110, 4};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; bit_req = 1'b0;
        in_data = '0; sel = 1'b0;
        repeat (3) tick;
        check_reset_vals("reset1");
        sel = 1'b1;
        #1;
        check_reset_vals("reset4");
        rst = 1'b0;
        tick;

        // bit_req while idle: no effect
        bit_req = 1'b1;
        tick;
        bit_req = 1'b0;
        check("idle_req_underrun", o_underrun, 0);
        check("idle_req_bit_valid", o_bit_valid, 0);

        // single-word frames from the table
        sel = 1'b0;
        tick;
        for (int v = 0; v < 4; v++) begin
            do_start;
            send_word(vecs[v].word);
            check("single_in_ready_low", o_in_ready, 0);
            for (int i = 0; i < W; i++)
                req_bit(vecs[v].gap, vecs[v].exp_bits[W-1-i], i == W - 1);
            tick;
            check("single_end_busy", o_busy, 0);
            check("single_end_in_ready", o_in_ready, 0);
            check("single_end_underrun", o_underrun, 0);
            check("single_end_bit_valid", o_bit_valid, 0);
        end

        // full four-word frame
        sel = 1'b1;
        tick;
        fw[0] = 24'h000001; fw[1] = 24'h000002; fw[2] = 24'h000003; fw[3] = 24'h000004;
        base_bv = nbv; base_done = ndone;
        do_start;
        run_frame;
        repeat (3) tick;
        check("frame_bit_valid_count", nbv - base_bv, 96);
        check("frame_done_count", ndone - base_done, 1);
        check("frame_in_ready", o_in_ready, 0);
        check("frame_busy", o_busy, 0);
        check("frame_underrun", o_underrun, 0);

        // underrun: request with no word loaded
        do_start;
        check("ur_clear_before", o_underrun, 0);
        base_bv = nbv;
        bit_req = 1'b1;
        tick;
        bit_req = 1'b0;
        check("ur_set", o_underrun, 1);
        check("ur_no_bit_valid", o_bit_valid, 0);
        tick;
        check("ur_no_bit_valid_late", nbv - base_bv, 0);
        fw[0] = 24'hC3C3C3; fw[1] = 24'h0F0F0F; fw[2] = 24'hFEDCBA; fw[3] = 24'h000080;
        base_bv = nbv; base_done = ndone;
        run_frame;
        tick;
        check("ur_frame_bits", nbv - base_bv, 96);
        check("ur_sticky", o_underrun, 1);
        do_start;
        check("ur_cleared_by_start", o_underrun, 0);

        // back-to-back: bit_req every cycle once the first word is in
        base_bv = nbv; base_done = ndone;
        send_word(24'h000001);
        widx = 1;
        bit_req = 1'b1;
        in_valid = 1'b1;
        in_data = 24'h000002;
        for (int c = 0; c < 140; c++) begin
            hs = o_in_ready && in_valid;
            tick;
            if (hs) widx++;
            in_valid = (widx < 4);
            in_data  = W'(widx + 1);
        end
        bit_req = 1'b0;
        in_valid = 1'b0;
        tick;
        check("b2b_bits", nbv - base_bv, 96);
        check("b2b_done", ndone - base_done, 1);
        check("b2b_words", widx, 4);
`ifdef LED_SERIALIZER_PREFETCH_EN
        check("b2b_underrun", o_underrun, 0);
        check("b2b_longest_run", bv_best, 96);
`else
        check("b2b_underrun", o_underrun, 1);
        check("b2b_longest_run", bv_best, 24);
`endif

        // start while busy is ignored, in LOAD and mid-shift
        do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("abuse_busy", o_busy, 1);
        check("abuse_in_ready", o_in_ready, 1);
        fw[0] = 24'h00F00F; fw[1] = 24'hAAAAAA; fw[2] = 24'h555555; fw[3] = 24'h800000;
        abuse_w = 1; abuse_b = 5;
        base_bv = nbv; base_done = ndone;
        run_frame;
        abuse_w = -1; abuse_b = -1;
        tick;
        check("abuse_bits", nbv - base_bv, 96);
        check("abuse_done", ndone - base_done, 1);
        check("abuse_underrun", o_underrun, 0);

        // reset at bit 10 of word 2
        do_start;
        bit_req = 1'b1;
        tick;
        bit_req = 1'b0;
        check("rst_pre_underrun", o_underrun, 1);
        send_word(24'h123456);
        for (int i = 0; i < W; i++) req_bit(1, vecs[3].exp_bits[W-1-i], 1'b0);
        send_word(24'hFFFFFF);
        for (int i = 0; i < 10; i++) req_bit(1, 1'b1, 1'b0);
        rst = 1'b1;
        tick;
        check_reset_vals("midrst");
        rst = 1'b0;
        tick;
        check("midrst_stays_idle", o_busy, 0);

        // clean frame after reset
        fw[0] = 24'h010203; fw[1] = 24'h040506; fw[2] = 24'h070809; fw[3] = 24'h0A0B0C;
        base_bv = nbv; base_done = ndone;
        do_start;
        run_frame;
        tick;
        check("post_rst_bits", nbv - base_bv, 96);
        check("post_rst_done", ndone - base_done, 1);
        check("post_rst_underrun", o_underrun, 0);
        check("post_rst_busy", o_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_frame_serializer.md
# led_frame_serializer

Parametrised successor to the single-word LED shift stage. It accepts a frame of `N_LEDS` colour words over a valid/ready stream and serialises each word MSB-first, one bit per downstream request. It sits between the frame source (pattern/snake logic) and the WS2812 bit encoder. It adds frame framing, a done pulse, underrun detection, and optional one-word prefetch for gapless output.

## Interface
- `W`, default 24: bits per LED word; legal range 2..32.
- `N_LEDS`, default 64: words per frame; must be ≥1.
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins a frame; ignored while `busy`.
- `in_valid`  in  1: `in_data` holds a word.
- `in_data`  in  W: colour word; bit W-1 is transmitted first.
- `in_ready`  out  1: the block accepts `in_data` this cycle.
- `bit_req`  in  1: the encoder requests the next bit (single-cycle pulse).
- `bit_out`  out  1: serial bit; holds its value between requests.
- `bit_valid`  out  1: one-cycle pulse; `bit_out` is new this cycle.
- `busy`  out  1: a frame is in progress.
- `done`  out  1: one-cycle pulse coincident with the frame's final `bit_valid`.
- `underrun`  out  1: sticky flag, set when `bit_req` arrives with no word loaded; cleared by `start` or `rst`.

## Operation
- **States:** IDLE, LOAD, SHIFT.
- **IDLE:**
  - `in_ready`=0; `bit_req` ignored, with no underrun.
  - `start` clears `underrun`, zeroes the word and bit counters, asserts `busy` next cycle, and moves to LOAD.
- **LOAD:**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: capture `in_data` into the shift register, increment the word count, and go to SHIFT.
  - `bit_req` in LOAD sets `underrun`; no `bit_valid` is produced and the request is dropped.
- **SHIFT:**
  - On `bit_req`: drive `bit_out`=shreg[W-1] and `bit_valid`=1 on the next cycle, shift the register left by one, and increment the bit count.
  - After the W-th bit, reset the bit count. If the word count is N_LEDS, assert `done` with that bit, go to IDLE, and drop `busy` in the same cycle. Otherwise go to LOAD.
- **Counters:** bit counter is `$clog2(W+1)` bits; word counter is `$clog2(N_LEDS+1)` bits. Neither wraps; both are cleared on `start`.
- **Start while busy:** ignored; the frame is unaffected.
- **Reset mid-frame:** the frame is abandoned, any buffered word is discarded, and the block returns to IDLE.
- **Frame size:** exactly N_LEDS words are accepted per frame. `in_ready` is never asserted for word N_LEDS+1.

## Timing
- Reset values: `in_ready`=0, `bit_out`=0, `bit_valid`=0, `busy`=0, `done`=0, `underrun`=0.
- `start` at cycle t: `busy`=1 and `in_ready`=1 at t+1.
- Handshake at t: SHIFT from t+1. A `bit_req` at t+1 gives `bit_valid` at t+2.
- `bit_req` at t in SHIFT gives `bit_valid` at t+1; latency is exactly one cycle.
- Word boundary (no prefetch): there is at least one LOAD cycle between words. A `bit_req` in that cycle is an underrun.
- `bit_req` in the same cycle as the accepting handshake counts as an underrun, because the word is not yet loaded.

## Configuration
- Macro: `LED_SERIALIZER_PREFETCH_EN`.
- **Defined:** a one-entry prefetch buffer is added.
  - `in_ready`=1 whenever `busy`, the buffer is empty, and fewer than N_LEDS words have been fetched, including during SHIFT.
  - At the end of the W-th bit, a full buffer loads directly into the shift register and SHIFT continues, so a `bit_req` on the very next cycle is served without underrun.
  - LOAD is entered only if the buffer is empty.
- **Undefined:** behaviour is exactly as in Operation; `in_ready` is asserted only in LOAD.

## Structure
- Shared package `led_pkg` holds:
  - the state enum (IDLE/LOAD/SHIFT);
  - `LED_WORD_W` = 24, the default for `W`;
  - `LED_COUNT`, the default for `N_LEDS`.
- Sub-module `led_word_buffer` is the one-entry valid/ready holding register. It is instantiated only under `LED_SERIALIZER_PREFETCH_EN`.

## Test plan
- **Single word:** `N_LEDS`=1, `W`=24; `start`, send 0xA5F00F, issue 24 `bit_req` pulses spaced 3 cycles apart.
  - Bits are 1010_0101_1111_0000_0000_1111, each one cycle after its request.
  - `done` pulses with the 24th bit; `busy` falls in that cycle.
- **Full frame:** 4 words 0x000001..0x000004.
  - Exactly 96 `bit_valid` pulses and one `done`.
  - `in_ready` stays low after the 4th handshake.
- **Underrun:** `start`, hold `in_valid`=0, pulse `bit_req`.
  - `underrun`=1 and no `bit_valid`.
  - The next `start` clears the flag.
- **Back-to-back (macro defined):** `bit_req` every cycle with `in_valid` held high.
  - 96 consecutive `bit_valid` pulses with no underrun.
  - Without the macro, an underrun occurs at the first word boundary.
- **Reset/start abuse:**
  - `start` mid-frame: ignored, frame completes normally.
  - `rst` at bit 10 of word 2: all outputs return to reset values next cycle.
  - A new `start` then runs a clean frame.
